// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared declarations for the UART transmit arbiter slice.
//   arb_state_t            - arbiter FSM states (IDLE, LAUNCH, WAIT)
//   UART_DATA_W            - width of one UART byte
//   UART_DONE_TIMEOUT_DEF  - default cycles allowed in WAIT before abort
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } arb_state_t;

    localparam int UART_DATA_W           = 8;
    localparam int UART_DONE_TIMEOUT_DEF = 2048;

endpackage

// File: rtl/uart_rr_pick.sv
// ---------------------------------------------------------------------------
// uart_rr_pick
// Combinational rotating-priority picker. Returns the first set request
// found by searching upward from rr_ptr, wrapping past NUM_REQ-1 to 0.
// Ports:
//   req        in   NUM_REQ   request vector
//   rr_ptr     in   IDX_W     index with highest priority this cycle
//   winner     out  IDX_W     index of the selected request (0 when none)
//   any_valid  out  1         at least one request is set
// ---------------------------------------------------------------------------
module uart_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any_valid
);

    // Rotate the requests so that bit k corresponds to requester rr_ptr+k.
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [2*NUM_REQ-1:0] req_shift;
    logic [NUM_REQ-1:0]   req_rot;

    assign req_dbl   = {req, req};
    assign req_shift = req_dbl >> rr_ptr;
    assign req_rot   = req_shift[NUM_REQ-1:0];

    always_comb begin
        // NOTE: every output gets a default before any branch; a path that
        // leaves one unassigned would otherwise infer a latch.
        winner    = '0;
        any_valid = 1'b0;
        // Walk from the farthest offset down to offset 0 so the request
        // nearest to rr_ptr is written last and wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                winner    = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter among NUM_REQ byte producers. Requesters are
// granted round-robin; each accepted byte is launched with a one-cycle
// tx_start and the next grant waits for tx_done (or a DONE_TIMEOUT abort).
//
// Optional feature, macro UART_ARB_LOCK_EN: a byte accepted with
// req_last=0 locks the arbiter to its requester until a byte with
// req_last=1 is accepted (or a timeout / reset clears the lock).
//
// Ports:
//   clk          in   1                 system clock
//   rst          in   1                 synchronous, active-high reset
//   req_valid    in   NUM_REQ           requester i offers a byte
//   req_data     in   8*NUM_REQ         byte of requester i on [8i+7:8i]
//   req_last     in   NUM_REQ           byte ends requester i's packet
//   req_ready    out  NUM_REQ           one-hot accept (IDLE only)
//   tx_start     out  1                 one-cycle launch pulse
//   tx_data      out  8                 byte held from accept until done
//   tx_busy      in   1                 serializer shifting
//   tx_done      in   1                 frame finished pulse
//   grant_id     out  $clog2(NUM_REQ)   owner of the current byte
//   active       out  1                 high in LAUNCH or WAIT
//   err_timeout  out  1                 one-cycle pulse on timeout abort
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DONE_TIMEOUT = UART_DONE_TIMEOUT_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           tx_start,
    output logic [UART_DATA_W-1:0]         tx_data,
    input  logic                           tx_busy,
    input  logic                           tx_done,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           active,
    output logic                           err_timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);
    // Wide enough to hold DONE_TIMEOUT-1, the largest value ever stored.
    localparam int CNT_W = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;

    arb_state_t       state;
    arb_state_t       state_next;
    logic [IDX_W-1:0] rr_ptr;
    logic [CNT_W-1:0] wait_cnt;
    logic             wait_term;
    logic [NUM_REQ-1:0] pick_req;
    logic [IDX_W-1:0] winner;
    logic             any_valid;
    logic             accept;

    // ---------------------------------------------------------------------
    // Request masking: with the lock feature only the lock owner competes.
    // ---------------------------------------------------------------------
`ifdef UART_ARB_LOCK_EN
    logic             lock_valid;
    logic [IDX_W-1:0] lock_id;

    always_comb begin
        pick_req = req_valid;
        if (lock_valid) begin
            pick_req = req_valid & (NUM_REQ'(1) << lock_id);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_valid <= 1'b0;
            lock_id    <= '0;
        end else if (accept) begin
            lock_valid <= ~req_last[winner];
            lock_id    <= winner;
        end else if (err_timeout) begin
            lock_valid <= 1'b0;
        end
    end
`else
    // Without the lock every byte is arbitrated on its own; req_last is
    // intentionally left without a load.
    logic unused_last;
    assign unused_last = ^req_last;
    assign pick_req    = req_valid;
`endif

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req       (pick_req),
        .rr_ptr    (rr_ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    assign wait_term = (wait_cnt == CNT_W'(DONE_TIMEOUT - 1));
    assign active    = (state != IDLE);

    // ---------------------------------------------------------------------
    // Next-state and handshake outputs.
    // ---------------------------------------------------------------------
    always_comb begin
        state_next  = state;
        req_ready   = '0;
        tx_start    = 1'b0;
        err_timeout = 1'b0;
        accept      = 1'b0;

        unique case (state)
            IDLE: begin
                if (any_valid) begin
                    req_ready  = NUM_REQ'(1) << winner;
                    accept     = 1'b1;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                if (!tx_busy) begin
                    tx_start   = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // tx_done takes precedence over a timeout in the same cycle.
                if (tx_done) begin
                    state_next = IDLE;
                end else if (wait_term) begin
                    err_timeout = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Pulses and handshakes are suppressed during the reset cycle so
        // nothing is accepted or launched while the state is being cleared.
        if (rst) begin
            req_ready   = '0;
            tx_start    = 1'b0;
            err_timeout = 1'b0;
            accept      = 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // State, pointer, data latch and WAIT counter.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples the values present before the clock edge.
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            tx_data  <= '0;
            grant_id <= '0;
            wait_cnt <= '0;
        end else begin
            state <= state_next;

            if (accept) begin
                tx_data  <= req_data[winner*UART_DATA_W +: UART_DATA_W];
                grant_id <= winner;
                rr_ptr   <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            end

            if (state == LAUNCH) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                if (tx_done || wait_term) begin
                    wait_cnt <= '0;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter (NUM_REQ=4, DONE_TIMEOUT=16).
// Requesters are FIFOs of {last,byte}; a serializer model answers tx_start
// with tx_busy and a tx_done pulse. A transaction-level reference tracks
// each byte from acceptance through launch to completion or timeout.
// Honors UART_ARB_LOCK_EN when defined.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int T   = 16;
    localparam int CAP = 256;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy;
    logic           tx_done;
    logic [1:0]     grant_id;
    logic           active;
    logic           err_timeout;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .DONE_TIMEOUT (T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .grant_id    (grant_id),
        .active      (active),
        .err_timeout (err_timeout)
    );

    int checks = 0;
    int errors = 0;

    // Requester FIFOs.
    logic [8:0] rbuf [N][CAP];
    int         rhead [N];
    int         rtail [N];
    bit         gap [N];
    bit         gap_en = 1'b0;

    // Serializer model.
    int frame_cnt  = 0;
    int frame_len  = 10;
    bit mute       = 1'b0;
    bit force_busy = 1'b0;
    bit rnd_len    = 1'b0;

    // Transaction-level reference.
    bit         m_txn      = 1'b0;
    bit         m_launched = 1'b0;
    int         m_wait     = 0;
    int         m_ptr      = 0;
    int         m_id       = 0;
    logic [7:0] m_byte     = 8'h00;
    bit         m_lock     = 1'b0;
    int         m_lock_id  = 0;

    int         cyc          = 0;
    int         last_acc_cyc = 0;
    int         log_id [$];
    logic [7:0] log_byte [$];
    int         start_cycs [$];
    int         err_cycs [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic void drive_inputs();
        for (int i = 0; i < N; i++) begin
            logic [8:0] e;
            e = (rhead[i] < rtail[i]) ? rbuf[i][rhead[i]] : 9'h000;
            req_valid[i]        = (rhead[i] < rtail[i]) && !gap[i];
            req_data[8*i +: 8]  = e[7:0];
            req_last[i]         = e[8];
        end
    endfunction

    function automatic void ser_drive();
        tx_busy = (frame_cnt > 0) || force_busy;
        tx_done = (frame_cnt == 1) && !mute;
    endfunction

    function automatic bit queues_empty();
        for (int i = 0; i < N; i++) begin
            if (rhead[i] < rtail[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic push(input int r, input logic [7:0] d, input bit last);
        if (rtail[r] < CAP) begin
            rbuf[r][rtail[r]] = {last, d};
            rtail[r]++;
        end
        drive_inputs();
    endtask

    // One clock cycle: check the DUT against the reference at the negedge,
    // then advance requesters and serializer just after the posedge.
    task automatic step();
        int           w;
        logic [N-1:0] vmask;
        logic [N-1:0] exp_ready;
        bit           start_ser;
        w         = -1;
        start_ser = 1'b0;
        exp_ready = '0;
        @(negedge clk);
        cyc++;
        if (rst) begin
            check("rst_ready", 32'(req_ready), 0);
            check("rst_start", 32'(tx_start), 0);
            check("rst_err", 32'(err_timeout), 0);
        end else if (!m_txn) begin
            vmask = req_valid;
            if (m_lock) vmask = req_valid & (N'(1) << m_lock_id);
            w = model_pick(vmask, m_ptr);
            if (w >= 0) exp_ready[w] = 1'b1;
            check("idle_ready", 32'(req_ready), 32'(exp_ready));
            check("idle_active", 32'(active), 0);
            check("idle_start", 32'(tx_start), 0);
            check("idle_err", 32'(err_timeout), 0);
            if (w >= 0) begin
                m_txn      = 1'b1;
                m_launched = 1'b0;
                m_id       = w;
                m_byte     = req_data[8*w +: 8];
                m_ptr      = (w + 1) % N;
`ifdef UART_ARB_LOCK_EN
                m_lock     = !req_last[w];
                m_lock_id  = w;
`endif
                last_acc_cyc = cyc;
            end
        end else if (!m_launched) begin
            check("launch_ready", 32'(req_ready), 0);
            check("launch_active", 32'(active), 1);
            check("launch_err", 32'(err_timeout), 0);
            check("launch_start", 32'(tx_start), 32'(!tx_busy));
            check("launch_data", 32'(tx_data), 32'(m_byte));
            check("launch_id", 32'(grant_id), m_id);
            if (!tx_busy) begin
                m_launched = 1'b1;
                m_wait     = 0;
                start_ser  = 1'b1;
                log_id.push_back(m_id);
                log_byte.push_back(m_byte);
                start_cycs.push_back(cyc);
            end
        end else begin
            check("wait_ready", 32'(req_ready), 0);
            check("wait_active", 32'(active), 1);
            check("wait_start", 32'(tx_start), 0);
            check("wait_data", 32'(tx_data), 32'(m_byte));
            check("wait_id", 32'(grant_id), m_id);
            if (tx_done) begin
                check("done_err", 32'(err_timeout), 0);
                m_txn = 1'b0;
            end else if (m_wait == T - 1) begin
                check("timeout_err", 32'(err_timeout), 1);
                m_txn  = 1'b0;
                m_lock = 1'b0;
                err_cycs.push_back(cyc);
            end else begin
                check("wait_err", 32'(err_timeout), 0);
                m_wait++;
            end
        end
        if (rst) begin
            m_txn      = 1'b0;
            m_launched = 1'b0;
            m_ptr      = 0;
            m_lock     = 1'b0;
        end
        @(posedge clk);
        #1;
        if (w >= 0) rhead[w]++;
        if (start_ser) frame_cnt = rnd_len ? int'($urandom_range(1, 20)) : frame_len;
        else if (frame_cnt > 0) frame_cnt--;
        for (int i = 0; i < N; i++) gap[i] = gap_en && ($urandom_range(0, 3) == 0);
        ser_drive();
        drive_inputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain(input string tag, input int limit);
        int n;
        n = 0;
        while (!(queues_empty() && !m_txn && frame_cnt == 0) && n < limit) begin
            step();
            n++;
        end
        check({tag, "_drain"}, 32'(n < limit), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic clear_logs();
        log_id.delete();
        log_byte.delete();
        start_cycs.delete();
        err_cycs.delete();
    endtask

    initial begin
        int n;
        int pushed;
        logic [7:0] exp_b [4];
        int         exp_i [4];

        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            rhead[i] = 0;
            rtail[i] = 0;
            gap[i]   = 1'b0;
        end
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        ser_drive();
        step();
        step();
        rst = 1'b0;

        // Reset values.
        check("reset_start", 32'(tx_start), 0);
        check("reset_data", 32'(tx_data), 0);
        check("reset_id", 32'(grant_id), 0);
        check("reset_active", 32'(active), 0);
        check("reset_err", 32'(err_timeout), 0);
        check("reset_ready", 32'(req_ready), 0);

        // Single request from requester 2.
        clear_logs();
        push(2, 8'hA5, 1'b1);
        step();
        drain("single", 200);
        check("single_count", log_id.size(), 1);
        if (log_id.size() == 1) begin
            check("single_id", log_id[0], 2);
            check("single_byte", 32'(log_byte[0]), 32'hA5);
            check("single_latency", start_cycs[0] - last_acc_cyc, 1);
        end
        // Stray tx_done while idle must be ignored.
        tx_done = 1'b1;
        step();
        run(5);
        check("single_no_more", log_id.size(), 1);

        // Round robin with all four requesters valid.
        do_reset();
        clear_logs();
        push(0, 8'h40, 1'b1);
        push(0, 8'h44, 1'b1);
        push(1, 8'h41, 1'b1);
        push(2, 8'h42, 1'b1);
        push(3, 8'h43, 1'b1);
        drain("rr", 400);
        check("rr_count", log_id.size(), 5);
        if (log_id.size() == 5) begin
            for (int k = 0; k < 5; k++) begin
                check("rr_id", log_id[k], k % N);
                check("rr_byte", 32'(log_byte[k]), 32'h40 + k);
            end
        end

        // tx_busy held for 5 cycles after accept.
        clear_logs();
        push(0, 8'h5A, 1'b1);
        step();
        force_busy = 1'b1;
        ser_drive();
        run(5);
        force_busy = 1'b0;
        ser_drive();
        drain("busy", 200);
        check("busy_count", log_id.size(), 1);
        if (log_id.size() == 1) begin
            check("busy_latency", start_cycs[0] - last_acc_cyc, 6);
            check("busy_byte", 32'(log_byte[0]), 32'h5A);
        end

        // Timeout: serializer never reports done.
        do_reset();
        clear_logs();
        mute      = 1'b1;
        frame_len = 20;
        push(1, 8'h71, 1'b1);
        push(3, 8'h73, 1'b1);
        drain("tmo", 400);
        check("tmo_errs", err_cycs.size(), 2);
        check("tmo_count", log_id.size(), 2);
        if (err_cycs.size() == 2 && log_id.size() == 2) begin
            check("tmo_delay", err_cycs[0] - start_cycs[0], T);
            check("tmo_first", log_id[0], 1);
            check("tmo_next", log_id[1], 3);
        end

        // tx_done on the terminal cycle beats the timeout.
        clear_logs();
        mute      = 1'b0;
        frame_len = T;
        push(2, 8'h72, 1'b1);
        drain("term", 200);
        check("term_errs", err_cycs.size(), 0);
        check("term_count", log_id.size(), 1);

        // Packet lock (interleaves when the feature is absent).
        do_reset();
        clear_logs();
        frame_len = 10;
        push(1, 8'h10, 1'b0);
        push(1, 8'h11, 1'b0);
        push(1, 8'h12, 1'b1);
        step();
        push(0, 8'h20, 1'b1);
        drain("lock", 400);
`ifdef UART_ARB_LOCK_EN
        exp_i = '{1, 1, 1, 0};
        exp_b = '{8'h10, 8'h11, 8'h12, 8'h20};
`else
        exp_i = '{1, 0, 1, 1};
        exp_b = '{8'h10, 8'h20, 8'h11, 8'h12};
`endif
        check("lock_count", log_id.size(), 4);
        if (log_id.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                check("lock_id", log_id[k], exp_i[k]);
                check("lock_byte", 32'(log_byte[k]), 32'(exp_b[k]));
            end
        end

        // Reset in the middle of WAIT.
        do_reset();
        clear_logs();
        mute      = 1'b1;
        frame_len = 30;
        push(2, 8'h55, 1'b1);
        n = 0;
        while (start_cycs.size() == 0 && n < 50) begin
            step();
            n++;
        end
        check("rstw_launched", start_cycs.size(), 1);
        run(4);
        do_reset();
        mute = 1'b0;
        check("rstw_start", 32'(tx_start), 0);
        check("rstw_data", 32'(tx_data), 0);
        check("rstw_id", 32'(grant_id), 0);
        check("rstw_active", 32'(active), 0);
        check("rstw_err", 32'(err_timeout), 0);
        check("rstw_ready", 32'(req_ready), 0);
        push(2, 8'h62, 1'b1);
        push(0, 8'h60, 1'b1);
        drain("rstw", 400);
        check("rstw_count", log_id.size(), 3);
        if (log_id.size() == 3) begin
            check("rstw_first", log_id[1], 0);
            check("rstw_second", log_id[2], 2);
        end

        // Randomized traffic with valid gaps and random frame lengths.
        do_reset();
        clear_logs();
        pushed  = 0;
        gap_en  = 1'b1;
        rnd_len = 1'b1;
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                push(int'($urandom_range(0, N - 1)), 8'($urandom), 1'($urandom_range(0, 1)));
                pushed++;
            end
            step();
        end
        gap_en = 1'b0;
        for (int i = 0; i < N; i++) begin
            push(i, 8'hF0 + 8'(i), 1'b1);
            pushed++;
        end
        drain("rand", 8000);
        check("rand_count", log_id.size(), pushed);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmitter among NUM_REQ byte producers. Each requester offers bytes on a valid/ready handshake. The arbiter grants them round-robin, launches each byte into the transmitter with a one-cycle start pulse, and holds the next grant until the transmitter reports completion. It sits between the command/response logic and the UART TX serializer, in the same baud domain as the UART receiver.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DONE_TIMEOUT, 2048, clock cycles allowed in WAIT for tx_done before abort

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  requester i offers a byte
- req_data  in  8*NUM_REQ  byte of requester i on bits [8i+7:8i]
- req_last  in  NUM_REQ  byte ends requester i's packet (used only with lock feature)
- req_ready  out  NUM_REQ  one-hot accept; transfer when req_valid[i] & req_ready[i]
- tx_start  out  1  one-cycle launch pulse to serializer
- tx_data  out  8  byte for serializer; stable from launch until tx_done
- tx_busy  in  1  serializer currently shifting
- tx_done  in  1  one-cycle pulse, frame (incl. stop bit) finished
- grant_id  out  $clog2(NUM_REQ)  index of requester owning current byte
- active  out  1  high in LAUNCH or WAIT
- err_timeout  out  1  one-cycle pulse on DONE_TIMEOUT abort

## Operation
- States: IDLE, LAUNCH, WAIT.
- IDLE:
  - Winner is the first i with req_valid[i] set, searching from rr_ptr upward with wrap.
  - req_ready is asserted combinationally for the winner only.
  - On transfer: latch tx_data and grant_id, set rr_ptr = winner+1 (mod NUM_REQ), go to LAUNCH.
  - No valid requester: stay in IDLE.
- LAUNCH:
  - If tx_busy=0: pulse tx_start and go to WAIT.
  - Otherwise hold with tx_start=0.
- WAIT:
  - On tx_done: go to IDLE.
  - Otherwise increment wait_cnt. At wait_cnt == DONE_TIMEOUT-1: pulse err_timeout, go to IDLE, clear wait_cnt.
- wait_cnt is cleared on entry to WAIT. It is wide enough for DONE_TIMEOUT-1 with no wrap.
- req_ready is all-zero outside IDLE and while rst is high.
- Simultaneous events:
  - tx_done in the same cycle as the timeout terminal count: tx_done wins, no err_timeout.
  - tx_done while in IDLE or LAUNCH: ignored.
- Requester dropping req_valid before acceptance is legal; arbitration re-evaluates every IDLE cycle.
- Reset values: tx_start=0, tx_data=0x00, grant_id=0, active=0, err_timeout=0, rr_ptr=0, state=IDLE, lock cleared.
- Reset mid-frame returns to IDLE immediately. The serializer is not notified.

## Timing
- Accept in cycle N.
- tx_start in cycle N+1 if tx_busy is low; otherwise in the first cycle after tx_busy falls.
- tx_done in cycle M, IDLE in M+1, earliest next accept in M+1.
- Back-to-back bytes from one requester therefore cost frame time + 2 cycles.
- Fairness: with all requesters valid, consecutive grants are 0,1,2,...,NUM_REQ-1,0 (no lock).

## Configuration
- UART_ARB_LOCK_EN defined:
  - Accepting a byte with req_last=0 sets lock to that requester.
  - While locked, IDLE grants only that requester. Others see req_ready=0 even if it idles.
  - Accepting a byte with req_last=1 clears the lock.
  - err_timeout and rst also clear the lock.
  - rr_ptr still advances to owner+1 on each accept, so the next grant after unlock rotates fairly.
- UART_ARB_LOCK_EN undefined:
  - req_last is ignored; every byte is arbitrated independently.
  - No lock register is synthesized.

## Structure
- Shared package uart_pkg holds:
  - arb_state_t enum (IDLE, LAUNCH, WAIT)
  - UART_DATA_W = 8
  - default timeout constant
- One sub-module, uart_rr_pick: combinational rotating-priority picker.
  - Inputs: request vector, rr_ptr.
  - Outputs: winner index, any_valid.
- The FSM, counters, lock and data latch stay in uart_tx_arbiter.

## Test plan
- Single request: req_valid[2]=1, data 0xA5 -> req_ready[2] for one cycle, tx_start next cycle, tx_data=0xA5, grant_id=2. After tx_done, idle with no further tx_start.
- Round robin: all four valid, serializer returns tx_done after 10 cycles -> grants 0,1,2,3,0, bytes in the same order.
- Busy hold: tx_busy=1 for 5 cycles after accept -> tx_start delayed exactly until the first cycle with tx_busy=0. tx_data stays stable throughout.
- Timeout: DONE_TIMEOUT=16, tx_done never sent -> err_timeout pulse 16 cycles after entering WAIT, then IDLE, next requester accepted. tx_done on the terminal cycle -> no err_timeout.
- Lock (with UART_ARB_LOCK_EN): requester 1 sends 0x10,0x11,0x12 with last on 0x12 while requester 0 is valid -> three bytes from 1 uninterrupted, then 0. Without the macro -> grants interleave 1,0.
- Reset mid-WAIT: assert rst for one cycle -> all outputs reach reset values next cycle. The first post-reset grant goes to requester 0 if it is valid.
